predictor_update_arbiter: RTL and testbench



---
 rtl/predictor_update_arbiter.sv | 155 +++++++++++++++
 tb/tb_predictor_update_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predictor_update_arbiter.sv
// Single-port write sequencer for branch predictor counter tables: clear sweep
// after reset, then two-lane round-robin arbitration into a small update FIFO.
module predictor_update_arbiter #(
  parameter int INDEX_LEN  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          is_stalling,
  input  logic                          req0_valid,
  input  logic [INDEX_LEN-1:0]          req0_index,
  input  logic                          req0_taken,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [INDEX_LEN-1:0]          req1_index,
  input  logic                          req1_taken,
  output logic                          req1_ready,
  output logic                          upd_enable,
  output logic [INDEX_LEN-1:0]          upd_index,
  output logic                          upd_taken,
  output logic                          upd_clear,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [INDEX_LEN-1:0] sweep_cnt;

  logic [INDEX_LEN-1:0] fifo_idx   [FIFO_DEPTH];
  logic                 fifo_taken [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 rr_ptr;

  logic                 in_init;
  logic                 in_run;
  logic                 sweep_wr;
  logic                 pop;
  logic                 space;
  logic                 grant0;
  logic                 grant1;
  logic                 accept0;
  logic                 accept1;
  logic                 push;
  logic [INDEX_LEN-1:0] push_idx;
  logic                 push_taken;

  assign in_init  = (state == S_INIT);
  assign in_run   = (state == S_RUN);
  assign sweep_wr = in_init && !is_stalling;
  assign pop      = in_run && !is_stalling && (occ != '0);

  // A full queue still has room when its head leaves in the same cycle.
  assign space  = (occ != OCC_FULL) || pop;
  assign grant0 = req0_valid && (!req1_valid || !rr_ptr);
  assign grant1 = req1_valid && (!req0_valid ||  rr_ptr);

  assign req0_ready = !reset && in_run && space && grant0;
  assign req1_ready = !reset && in_run && space && grant1;

  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign push       = accept0 || accept1;
  assign push_idx   = accept1 ? req1_index : req0_index;
  assign push_taken = accept1 ? req1_taken : req0_taken;

  assign occupancy = reset ? '0 : occ;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state; RUN is left only through reset
  always_comb begin
    state_nxt = state;
    if (sweep_wr && (&sweep_cnt)) begin
      state_nxt = S_RUN;
    end
  end

  // FSM: outputs; forced idle while reset is held
  always_comb begin
    upd_enable = 1'b0;
    upd_clear  = 1'b0;
    upd_index  = '0;
    upd_taken  = 1'b0;
    init_done  = 1'b0;
    if (!reset) begin
      if (in_init) begin
        upd_enable = sweep_wr;
        upd_clear  = sweep_wr;
        upd_index  = sweep_cnt;
      end else begin
        init_done  = 1'b1;
        upd_enable = pop;
        if (pop) begin
          upd_index = fifo_idx[rd_ptr];
          upd_taken = fifo_taken[rd_ptr];
        end
      end
    end
  end

  // Control state: sweep counter, queue pointers, occupancy, round-robin
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      if (sweep_wr) begin
        sweep_cnt <= sweep_cnt + INDEX_LEN'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= accept0;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= push_idx;
      fifo_taken[wr_ptr] <= push_taken;
    end
  end

endmodule

// File: tb/tb_predictor_update_arbiter.sv
// Directed bench for predictor_update_arbiter: a queue-based reference model is
// compared every cycle, alongside hand-computed literal checks.
module tb_predictor_update_arbiter;

  localparam int IL    = 3;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IL;

  logic          clk;
  logic          reset;
  logic          is_stalling;
  logic          req0_valid;
  logic [IL-1:0] req0_index;
  logic          req0_taken;
  logic          req0_ready;
  logic          req1_valid;
  logic [IL-1:0] req1_index;
  logic          req1_taken;
  logic          req1_ready;
  logic          upd_enable;
  logic [IL-1:0] upd_index;
  logic          upd_taken;
  logic          upd_clear;
  logic          init_done;
  logic [$clog2(DEPTH):0] occupancy;

  predictor_update_arbiter #(.INDEX_LEN(IL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .is_stalling(is_stalling),
    .req0_valid(req0_valid), .req0_index(req0_index), .req0_taken(req0_taken),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_index(req1_index), .req1_taken(req1_taken),
    .req1_ready(req1_ready),
    .upd_enable(upd_enable), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_clear(upd_clear), .init_done(init_done), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: pending updates as a plain queue, sweep as an integer.
  typedef struct { int idx; int tk; } ent_t;
  ent_t m_q[$];
  int   m_sweep = 0;
  bit   m_done  = 0;
  int   m_rr    = 0;

  task automatic model_out(output int en, output int clr, output int idx,
                           output int tk, output int r0, output int r1,
                           output int done, output int occ);
    bit p, sp, w0, w1;
    en = 0; clr = 0; idx = 0; tk = 0; r0 = 0; r1 = 0; done = 0; occ = 0;
    if (reset) return;
    occ = m_q.size();
    if (!m_done) begin
      en  = is_stalling ? 0 : 1;
      clr = en;
      idx = m_sweep;
      return;
    end
    done = 1;
    p  = !is_stalling && (m_q.size() > 0);
    sp = (m_q.size() < DEPTH) || p;
    if (p) begin
      en  = 1;
      idx = m_q[0].idx;
      tk  = m_q[0].tk;
    end
    w0 = req0_valid && (!req1_valid || m_rr == 0);
    w1 = req1_valid && (!req0_valid || m_rr == 1);
    r0 = (w0 && sp) ? 1 : 0;
    r1 = (w1 && sp) ? 1 : 0;
  endtask

  always @(posedge clk) begin
    int en, clr, idx, tk, r0, r1, done, occ;
    ent_t e;
    model_out(en, clr, idx, tk, r0, r1, done, occ);
    if (reset) begin
      m_q.delete();
      m_sweep = 0;
      m_done  = 0;
      m_rr    = 0;
    end else if (!m_done) begin
      if (!is_stalling) begin
        if (m_sweep == NENT - 1) m_done = 1;
        m_sweep = (m_sweep + 1) % NENT;
      end
    end else begin
      if (en != 0) void'(m_q.pop_front());
      if (r0 != 0) begin
        e.idx = int'(req0_index); e.tk = int'(req0_taken);
        m_q.push_back(e);
        m_rr = 1;
      end else if (r1 != 0) begin
        e.idx = int'(req1_index); e.tk = int'(req1_taken);
        m_q.push_back(e);
        m_rr = 0;
      end
    end
  end

  always @(negedge clk) begin
    int en, clr, idx, tk, r0, r1, done, occ;
    model_out(en, clr, idx, tk, r0, r1, done, occ);
    chk("m_upd_enable", int'(upd_enable), en);
    chk("m_upd_clear",  int'(upd_clear),  clr);
    chk("m_upd_index",  int'(upd_index),  idx);
    chk("m_upd_taken",  int'(upd_taken),  tk);
    chk("m_req0_ready", int'(req0_ready), r0);
    chk("m_req1_ready", int'(req1_ready), r1);
    chk("m_init_done",  int'(init_done),  done);
    chk("m_occupancy",  int'(occupancy),  occ);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    int k;
    reset = 1'b1; is_stalling = 1'b0;
    req0_valid = 1'b0; req0_index = '0; req0_taken = 1'b0;
    req1_valid = 1'b0; req1_index = '0; req1_taken = 1'b0;

    // Plain sweep with lane 0 requesting throughout INIT
    at_neg();
    chk("rst_en",   int'(upd_enable), 0);
    chk("rst_occ",  int'(occupancy),  0);
    chk("rst_done", int'(init_done),  0);
    tick();
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_index = 3'd4;
    for (int c = 1; c <= NENT; c++) begin
      at_neg();
      chk("t1_en",   int'(upd_enable), 1);
      chk("t1_clr",  int'(upd_clear),  1);
      chk("t1_idx",  int'(upd_index),  c - 1);
      chk("t1_rdy0", int'(req0_ready), 0);
      tick();
    end
    req0_valid = 1'b0;
    at_neg();
    chk("t1_done", int'(init_done),  1);
    chk("t1_en9",  int'(upd_enable), 0);
    tick();

    // Sweep with stall in cycles 3..5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      is_stalling = (c >= 3 && c <= 5);
      at_neg();
      if (c == 3 || c == 5) begin
        chk("t2_stall_en",  int'(upd_enable), 0);
        chk("t2_stall_idx", int'(upd_index),  2);
      end
      if (c == 6)  chk("t2_resume_idx", int'(upd_index), 2);
      if (c == 11) begin
        chk("t2_last_en",  int'(upd_enable), 1);
        chk("t2_last_idx", int'(upd_index),  7);
        chk("t2_last_done", int'(init_done), 0);
      end
      tick();
    end
    is_stalling = 1'b0;
    at_neg();
    chk("t2_done", int'(init_done), 1);
    tick();

    // Both lanes valid for four cycles
    req0_valid = 1'b1; req0_index = 3'd5; req0_taken = 1'b1;
    req1_valid = 1'b1; req1_index = 3'd6; req1_taken = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      at_neg();
      chk("t3_r0", int'(req0_ready), (a % 2 == 1) ? 1 : 0);
      chk("t3_r1", int'(req1_ready), (a % 2 == 0) ? 1 : 0);
      if (a == 1) chk("t3_en1", int'(upd_enable), 0);
      if (a >= 2) begin
        chk("t3_idx", int'(upd_index), (a % 2 == 0) ? 5 : 6);
        chk("t3_tk",  int'(upd_taken), (a % 2 == 0) ? 1 : 0);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    at_neg();
    chk("t3_idx5", int'(upd_index), 6);
    chk("t3_tk5",  int'(upd_taken), 0);
    tick();
    at_neg();
    chk("t3_empty", int'(occupancy), 0);
    tick();

    // Stalled stream fills the queue, then pop and push share a cycle
    is_stalling = 1'b1;
    req0_valid = 1'b1;
    k = 1;
    for (int s = 1; s <= 6; s++) begin
      req0_index = k[IL-1:0]; req0_taken = k[0];
      at_neg();
      if (s >= 5) begin
        chk("t4_full_occ", int'(occupancy),  4);
        chk("t4_full_rdy", int'(req0_ready), 0);
      end
      if (req0_ready) k++;
      tick();
    end
    is_stalling = 1'b0;
    req0_index = k[IL-1:0]; req0_taken = k[0];
    at_neg();
    chk("t4_pp_rdy", int'(req0_ready), 1);
    chk("t4_pp_en",  int'(upd_enable), 1);
    chk("t4_pp_idx", int'(upd_index),  1);
    chk("t4_pp_occ", int'(occupancy),  4);
    tick();
    req0_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      at_neg();
      chk("t4_drain_idx", int'(upd_index), d + 2);
      tick();
    end
    at_neg();
    chk("t4_drained", int'(upd_enable), 0);
    tick();

    // Reset with three queued updates
    is_stalling = 1'b1;
    req0_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      req0_index = 3'(j + 2); req0_taken = 1'b1;
      at_neg();
      chk("t5_fill_rdy", int'(req0_ready), 1);
      tick();
    end
    req0_valid = 1'b0;
    at_neg();
    chk("t5_occ3", int'(occupancy), 3);
    tick();
    reset = 1'b1; is_stalling = 1'b0;
    tick();
    reset = 1'b0;
    at_neg();
    chk("t5_occ",  int'(occupancy), 0);
    chk("t5_done", int'(init_done), 0);
    chk("t5_en",   int'(upd_enable), 1);
    chk("t5_clr",  int'(upd_clear),  1);
    chk("t5_idx",  int'(upd_index),  0);
    tick();
    repeat (NENT - 1) tick();
    for (int j = 0; j < 4; j++) begin
      at_neg();
      chk("t5_no_issue", int'(upd_enable), 0);
      tick();
    end

    // Single lane back-to-back
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) begin
        req1_valid = 1'b1; req1_index = 3'(j + 3); req1_taken = j[0];
      end else begin
        req1_valid = 1'b0;
      end
      at_neg();
      if (j < 5) chk("t6_rdy", int'(req1_ready), 1);
      chk("t6_occ", int'(occupancy), (j == 0) ? 0 : 1);
      if (j > 0) begin
        chk("t6_en",  int'(upd_enable), 1);
        chk("t6_idx", int'(upd_index),  j + 2);
      end
      tick();
    end
    at_neg();
    chk("t6_end_en",  int'(upd_enable), 0);
    chk("t6_end_occ", int'(occupancy),  0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
